i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 Parameter DEV_ADDR, default 7'b1001101: 7-bit slave address matched against the address byte.
REQ-002 Parameter NUM_REGS, default 4: number of 8-bit registers reachable through the pointer (1..256).
REQ-003 Parameter PTR_W, default 2: pointer width; SHALL satisfy 2**PTR_W >= NUM_REGS.
REQ-004 Clk  input  1  single system clock; all logic on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 Scl_in  input  1  raw I2C SCL level, asynchronous to Clk.
REQ-007 Sda_in  input  1  raw I2C SDA level, asynchronous to Clk.
REQ-008 Sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-009 Reg_addr  output  PTR_W  current register pointer.
REQ-010 Reg_wdata  output  8  byte written by master.
REQ-011 Reg_we  output  1  one-cycle write strobe; Reg_addr/Reg_wdata valid in that cycle.
REQ-012 Reg_rdata  input  8  combinational read data for Reg_addr.
REQ-013 Ready  output  1  high only in IDLE.
REQ-014 Error  output  1  one-cycle pulse on pointer out of range or protocol violation.

Function
REQ-015 Scl_in/Sda_in SHALL pass a 2-flop synchroniser plus one edge-detect stage; internal event latency 3 Clk cycles from pin change.
REQ-016 START = synchronised SDA falling while SCL high; STOP = SDA rising while SCL high.
REQ-017 Data bits SHALL be sampled on synchronised SCL rising edge, MSB first; Sda_oe changes only on SCL falling edge.
REQ-018 States: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, MACK, WAIT_STOP.
REQ-019 IDLE -> ADDR on START; 3-bit bit counter cleared.
REQ-020 ADDR -> ACK_ADDR after 8th bit; addr[7:1]==DEV_ADDR: Sda_oe=1 for the ACK clock; mismatch: no ACK, -> WAIT_STOP.
REQ-021 After ACK_ADDR SCL falling: R/W=0 -> PTR; R/W=1 -> RDATA using current pointer.
REQ-022 PTR -> ACK_PTR after 8 bits; value < NUM_REGS: ACK, pointer loaded, -> WDATA; else NACK, Error pulse, pointer unchanged, -> WAIT_STOP.
REQ-023 WDATA -> ACK_WDATA after 8 bits; Reg_we pulses exactly once with the byte, Sda_oe=1 for ACK; then -> WDATA.
REQ-024 RDATA: Reg_rdata latched into shift register at SCL falling ending ACK_ADDR/MACK; bit 7 driven first (Sda_oe = ~bit); after 8 bits release SDA -> MACK.
REQ-025 MACK: master ACK (SDA low at SCL rise) -> RDATA next byte; NACK -> WAIT_STOP.
REQ-026 START in any non-IDLE state SHALL go to ADDR (repeated start), pointer preserved; STOP in any state -> IDLE, Sda_oe=0 next cycle.
REQ-027 START and SCL edge detected same cycle: START wins.
REQ-028 Pointer persists across transactions; only REQ-022 and REQ-034 modify it.
REQ-029 SDA change while SCL high inside a data bit, other than START/STOP, does not occur; no recovery beyond REQ-026 required.

Reset
REQ-030 Rst high on a Clk edge: state=IDLE, pointer=0, bit counter=0, shift register=0.
REQ-031 During/after reset: Sda_oe=0, Reg_we=0, Error=0, Reg_wdata=0, Ready=1.
REQ-032 Reset mid-transfer SHALL abort it immediately; no Reg_we issued for a partial byte.
REQ-033 Synchroniser flops reset to 1 (bus idle) so reset release does not create false START/STOP.

Configuration
REQ-034 Macro I2C_SLAVE_AUTOINC_EN defined: pointer increments after each written byte (ACK_WDATA) and each read byte (MACK), wrapping NUM_REGS-1 -> 0.
REQ-035 Macro undefined: pointer never auto-increments; repeated bytes read/write the same register.

Verification
REQ-036 Write: START, 0x9A, ptr 0x01, data 0x5C, STOP -> 3 ACKs, one Reg_we with Reg_addr=1, Reg_wdata=0x5C, Ready=1 after STOP.
REQ-037 Read with repeated start: 0x9A, ptr 0x02, Sr, 0x9B, Reg_rdata=0xA5, master NACK -> SDA shows 0xA5 MSB first, no Reg_we, -> WAIT_STOP.
REQ-038 Address 0x90 -> no ACK (Sda_oe=0 throughout), no Reg_we until next START.
REQ-039 NUM_REGS=4, ptr 0x07 -> NACK, one Error pulse, pointer stays at prior value.
REQ-040 AUTOINC_EN, pointer 3, write 0x11,0x22 -> Reg_we at addr 3 then 0; macro undefined -> both at addr 3.
REQ-041 Rst asserted after 4 data bits of WDATA -> Sda_oe=0, no Reg_we, state IDLE; next transaction completes normally.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing NUM_REGS 8-bit registers through a pointer byte; oversampled on Clk.
// Optional pointer auto-increment when I2C_SLAVE_AUTOINC_EN is defined.
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'b1001101,
  parameter int         NUM_REGS = 4,
  parameter int         PTR_W    = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Scl_in,
  input  logic             Sda_in,
  output logic             Sda_oe,
  output logic [PTR_W-1:0] Reg_addr,
  output logic [7:0]       Reg_wdata,
  output logic             Reg_we,
  input  logic [7:0]       Reg_rdata,
  output logic             Ready,
  output logic             Error
);

`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, MACK, WAIT_STOP
  } state_t;

  // [0],[1] synchronise, [2] is the previous level for edge detection
  logic [2:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             we_q, we_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  logic             scl_lvl, scl_rise, scl_fall, sda_lvl, start_det, stop_det;
  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_inc;

  assign scl_lvl   = scl_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign sda_lvl   = sda_sync_q[1];
  assign start_det = scl_lvl & ~sda_sync_q[1] & sda_sync_q[2];
  assign stop_det  = scl_lvl & sda_sync_q[1] & ~sda_sync_q[2];
  assign rx_byte   = {shift_q[6:0], sda_lvl};
  assign ptr_inc   = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], Scl_in};
    sda_sync_d = {sda_sync_q[1:0], Sda_in};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
    // Bus conditions take priority over any SCL edge seen in the same cycle
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7)
            state_d = (rx_byte[7:1] == DEV_ADDR) ? ACK_ADDR : WAIT_STOP;
        end
        ACK_ADDR: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (shift_q[0]) begin
            state_d   = RDATA;
            shift_d   = Reg_rdata;
            sda_oe_d  = ~Reg_rdata[7];
            bit_cnt_d = 3'd0;
          end else begin
            state_d   = PTR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
          end
        end
        PTR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
              ptr_d   = PTR_W'(rx_byte);
              state_d = ACK_PTR;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_STOP;
            end
          end
        end
        ACK_PTR, ACK_WDATA: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            state_d   = WDATA;
            bit_cnt_d = 3'd0;
            if (AUTOINC && state_q == ACK_WDATA) ptr_d = ptr_inc;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            we_d    = 1'b1;
            wdata_d = rx_byte;
            state_d = ACK_WDATA;
          end
        end
        // Counter wraps to 0 after the 8th rise, so a fall with count 0 ends the byte
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = MACK;
            end else begin
              shift_d  = {shift_q[6:0], shift_q[7]};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        // Increment on the rise so Reg_rdata follows the new pointer by the fall
        MACK: begin
          if (scl_rise) begin
            if (AUTOINC) ptr_d = ptr_inc;
            if (!sda_lvl) bit_cnt_d = 3'd1;
            else          state_d   = WAIT_STOP;
          end else if (scl_fall && bit_cnt_q == 3'd1) begin
            state_d   = RDATA;
            shift_d   = Reg_rdata;
            sda_oe_d  = ~Reg_rdata[7];
            bit_cnt_d = 3'd0;
          end
        end
        default: ;
      endcase
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign Sda_oe    = sda_oe_q;
  assign Reg_addr  = ptr_q;
  assign Reg_wdata = wdata_q;
  assign Reg_we    = we_q;
  assign Error     = err_q;
  assign Ready     = ready_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, transaction-level register model,
// and a per-cycle monitor checking write strobes and error pulses against the model.
module tb_i2c_slave_regs;
  localparam int         Q    = 8;
  localparam int         NREG = 4;
  localparam logic [6:0] DEV  = 7'b1001101;

  logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic       sda_line, sda_oe, reg_we, ready, error;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic [7:0] regs_mem [NREG];

  always #5 clk = ~clk;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = regs_mem[reg_addr];

  i2c_slave_regs dut (
    .Clk(clk), .Rst(rst), .Scl_in(scl), .Sda_in(sda_line), .Sda_oe(sda_oe),
    .Reg_addr(reg_addr), .Reg_wdata(reg_wdata), .Reg_we(reg_we),
    .Reg_rdata(reg_rdata), .Ready(ready), .Error(error)
  );

  always @(posedge clk) if (reg_we) regs_mem[reg_addr] <= reg_wdata;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model
  typedef struct { logic [1:0] a; logic [7:0] d; } wr_t;
  logic [7:0] model_regs [NREG];
  logic [1:0] model_ptr = 2'd0;
  bit         m_active  = 1'b0;
  wr_t        exp_wq [$];
  int         exp_err   = 0;
  int         err_seen  = 0;
  logic [1:0] we_log [$];
  logic [7:0] last_wdata;

  task automatic model_inc();
`ifdef I2C_SLAVE_AUTOINC_EN
    model_ptr = 2'((int'(model_ptr) + 1) % NREG);
`endif
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (reg_we) begin
      if (exp_wq.size() == 0) begin
        check("unexpected_we", reg_we, 0);
      end else begin
        e = exp_wq.pop_front();
        check("we_addr", reg_addr, e.a);
        check("we_data", reg_wdata, e.d);
      end
      we_log.push_back(reg_addr);
      last_wdata = reg_wdata;
    end
    if (error) begin
      err_seen++;
      if (exp_err == 0) check("unexpected_err", error, 0);
      else exp_err--;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    sda_m = b; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    seen = sda_line; wait_clk(Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(b[i], seen);
      check({name, "_bit"}, seen, b[i]);
    end
    bus_bit(1'b1, seen);
    check({name, "_ack"}, seen, !exp_ack);
    $display("byte %s 0x%02h ack_line=%0b", name, b, seen);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] got);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, seen);
      got[i] = seen;
    end
    bus_bit(!mack, seen);
  endtask

  task automatic m_addr(input logic [7:0] b);
    logic ack;
    ack = (b[7:1] == DEV);
    wr_byte(b, ack, "addr");
    m_active = ack;
  endtask

  task automatic m_ptr(input logic [7:0] b);
    logic ack;
    ack = m_active && (int'(b) < NREG);
    if (m_active && !ack) exp_err++;
    wr_byte(b, ack, "ptr");
    if (ack) model_ptr = 2'(b);
    m_active = ack;
  endtask

  task automatic m_data(input logic [7:0] b);
    logic act;
    act = m_active;
    if (act) begin
      exp_wq.push_back('{model_ptr, b});
      model_regs[model_ptr] = b;
    end
    wr_byte(b, act, "wdata");
    if (act) model_inc();
  endtask

  task automatic m_read(input logic mack, output logic [7:0] got);
    logic [7:0] exp;
    exp = model_regs[model_ptr];
    rd_byte(mack, got);
    check("rdata", got, exp);
    $display("read 0x%02h expected 0x%02h mack=%0b", got, exp, mack);
    model_inc();
    m_active = mack;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got0, got1;
    logic       seen;
    int         e0;
    logic [7:0] init_vals [NREG];
    init_vals = '{8'h10, 8'h21, 8'hA5, 8'h43};
    for (int i = 0; i < NREG; i++) begin
      regs_mem[i]   = init_vals[i];
      model_regs[i] = init_vals[i];
    end

    // Reset state
    wait_clk(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_we", reg_we, 0);
    check("rst_err", error, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_ready", ready, 1);
    check("rst_addr", reg_addr, 0);
    rst = 1'b0;
    wait_clk(4);
    check("post_rst_ready", ready, 1);
    check("post_rst_sda_oe", sda_oe, 0);

    // Plain write
    we_log.delete();
    bus_start();
    check("ready_busy", ready, 0);
    m_addr(8'h9A); m_ptr(8'h01); m_data(8'h5C);
    bus_stop();
    check("w_ready", ready, 1);
    check("w_we_count", we_log.size(), 1);
    if (we_log.size() == 1) check("w_addr_lit", we_log[0], 2'd1);
    check("w_data_lit", last_wdata, 8'h5C);
    check("w_ptr", reg_addr, model_ptr);

    // Pointer write, repeated start, read with master NACK
    we_log.delete();
    bus_start(); m_addr(8'h9A); m_ptr(8'h02);
    bus_start(); m_addr(8'h9B); m_read(1'b0, got0);
    check("r_lit", got0, 8'hA5);
    check("r_wait_stop", ready, 0);
    bus_stop();
    check("r_ready", ready, 1);
    check("r_no_we", we_log.size(), 0);
    check("r_ptr", reg_addr, model_ptr);

    // Foreign address: no ACK, nothing written
    bus_start(); m_addr(8'h90); m_ptr(8'h01); m_data(8'h33);
    bus_stop();
    check("na_no_we", we_log.size(), 0);
    check("na_ptr", reg_addr, model_ptr);

    // Out-of-range pointer
    e0 = err_seen;
    bus_start(); m_addr(8'h9A); m_ptr(8'h07);
    bus_stop();
    check("oor_err_pulses", err_seen - e0, 1);
    check("oor_ptr", reg_addr, model_ptr);

    // Two data bytes from pointer 3
    we_log.delete();
    bus_start(); m_addr(8'h9A); m_ptr(8'h03); m_data(8'h11); m_data(8'h22);
    bus_stop();
    check("ai_we_count", we_log.size(), 2);
    if (we_log.size() == 2) begin
      check("ai_addr0", we_log[0], 2'd3);
`ifdef I2C_SLAVE_AUTOINC_EN
      check("ai_addr1", we_log[1], 2'd0);
`else
      check("ai_addr1", we_log[1], 2'd3);
`endif
    end
    check("ai_ptr", reg_addr, model_ptr);

    // Reset after four data bits
    we_log.delete();
    bus_start(); m_addr(8'h9A); m_ptr(8'h01);
    for (int i = 7; i >= 4; i--) begin
      bus_bit(init_vals[1][i] ^ 1'b1, seen);
      check("part_bit", seen, init_vals[1][i] ^ 1'b1);
    end
    rst = 1'b1; wait_clk(2); rst = 1'b0;
    model_ptr = 2'd0; m_active = 1'b0;
    wait_clk(2);
    check("mr_sda_oe", sda_oe, 0);
    check("mr_ready", ready, 1);
    check("mr_addr", reg_addr, 0);
    sda_m = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    check("mr_no_we", we_log.size(), 0);
    bus_start(); m_addr(8'h9A); m_ptr(8'h02); m_data(8'h77);
    bus_stop();
    check("mr_after_we", we_log.size(), 1);

    // Read two bytes: master ACK then NACK
    bus_start(); m_addr(8'h9A); m_ptr(8'h02);
    bus_start(); m_addr(8'h9B);
    m_read(1'b1, got0);
    m_read(1'b0, got1);
    bus_stop();
    check("r2_lit", got0, 8'h77);
    check("r2_ptr", reg_addr, model_ptr);

    wait_clk(4);
    check("wq_empty", exp_wq.size(), 0);
    check("err_consumed", exp_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
